// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: opcodes, control states,
// mux selects and the control word driven by the main controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational state -> control word decoder. Only pc_en and illegal_op look
// past the state, at the ALU zero flag and the opcode respectively.
module mips_mc_ctrl_decode
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [3:0]     state_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           zero_i,
    output ctrl_t          ctrl_o,
    output logic           pc_en_o,
    output logic           illegal_op_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_src    = PCSRC_ALU;
            end
            // Branch target is computed speculatively here and parked in ALUOut.
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

    assign pc_en_o      = ctrl_o.pc_write | (ctrl_o.pc_write_cond & zero_i);
    assign illegal_op_o = (state_i == S_DECODE) && !op_supported(opcode_i[5:0]);

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS: state register and next-state
// logic; the control word itself comes from mips_mc_ctrl_decode.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW_ = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           pc_en,
    output logic [1:0]     pc_src,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           illegal_op,
    output logic [SW_-1:0] state
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode[5:0])
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode[5:0] == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_mc_ctrl_decode #(.OPW(OPW)) u_decode (
        .state_i      (state_q),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .ctrl_o       (ctrl),
        .pc_en_o      (pc_en),
        .illegal_op_o (illegal_op)
    );

    assign pc_src     = ctrl.pc_src;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign state      = SW_'(state_q);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: expected per-cycle state/control words
// are queued per instruction and popped against the DUT one cycle at a time.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
    logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;

    int errs = 0;
    int checks = 0;

    typedef struct {
        int         st;
        logic [5:0] op;
        logic       z;
        logic       zfix;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mips_mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
        .state(state)
    );

    wire [15:0] got_cw = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write,
                          reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                          alu_op, illegal_op};

    // Field order: pc_en pc_src i_or_d mem_read mem_write ir_write reg_dst
    //              mem_to_reg reg_write alu_src_a alu_src_b alu_op illegal_op
    function automatic logic [15:0] exp_cw(input int st, input logic [5:0] op, input logic z);
        logic ill;
        ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                op == 6'b000100 || op == 6'b001000 || op == 6'b000010);
        case (st)
            0:  return 16'b1_00_0_1_0_1_0_0_0_0_01_00_0;
            1:  return {15'b0_00_0_0_0_0_0_0_0_0_11_00, ill};
            2:  return 16'b0_00_0_0_0_0_0_0_0_1_10_00_0;
            3:  return 16'b0_00_1_1_0_0_0_0_0_0_00_00_0;
            4:  return 16'b0_00_0_0_0_0_0_1_1_0_00_00_0;
            5:  return 16'b0_00_1_0_1_0_0_0_0_0_00_00_0;
            6:  return 16'b0_00_0_0_0_0_0_0_0_1_00_10_0;
            7:  return 16'b0_00_0_0_0_0_1_0_1_0_00_00_0;
            8:  return {z, 15'b01_0_0_0_0_0_0_0_1_00_01_0};
            9:  return 16'b0_00_0_0_0_0_0_0_0_1_10_00_0;
            10: return 16'b0_00_0_0_0_0_0_0_1_0_00_00_0;
            11: return 16'b1_10_0_0_0_0_0_0_0_0_00_00_0;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input int st, input logic [5:0] op, input logic z,
                        input logic zfix, input string tag);
        exp_t e;
        e.st = st; e.op = op; e.z = z; e.zfix = zfix; e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected state walk for one instruction, FETCH up to the cycle before
    // the return to FETCH. zero is held only where it matters (BRANCH).
    task automatic push_instr(input logic [5:0] op, input logic z, input string tag);
        int seq[$];
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
        foreach (seq[i]) push(seq[i], op, z, seq[i] == 8, tag);
    endtask

    // Called at posedge+1: drive, compare the front entry, leave the clock alone.
    task automatic check_front();
        exp_t e;
        logic [15:0] want;
        e = sb.pop_front();
        opcode = e.op;
        zero = e.zfix ? e.z : 1'($urandom_range(0, 1));
        #1;
        want = exp_cw(e.st, e.op, zero);
        checks++;
        assert (state === 4'(e.st)) else begin
            errs++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        checks++;
        assert (got_cw === want) else begin
            errs++;
            $error("FAIL %s ctrl st%0d: got %b expected %b", e.tag, e.st, got_cw, want);
        end
        checks++;
        assert (!(mem_read && mem_write)) else begin
            errs++;
            $error("FAIL %s rd_wr_excl st%0d: got rd=%b wr=%b expected not both", e.tag, e.st, mem_read, mem_write);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            check_front();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_instr(6'b100011, 1'b0, "reset_lw");
        drain();
        push_instr(6'b000100, 1'b1, "beq_taken");
        drain();
        push_instr(6'b000100, 1'b0, "beq_not_taken");
        drain();
        push_instr(6'b101011, 1'b0, "sw");
        drain();
        push_instr(6'b111111, 1'b0, "illegal");
        drain();
        push_instr(6'b000000, 1'b0, "rtype");
        drain();
        push_instr(6'b001000, 1'b0, "addi");
        drain();
        push_instr(6'b000010, 1'b0, "jump");
        drain();
        // Reset asserted while LW sits in MEMRD must abort back to FETCH.
        push(0, 6'b100011, 1'b0, 1'b0, "rst_mid");
        push(1, 6'b100011, 1'b0, 1'b0, "rst_mid");
        push(2, 6'b100011, 1'b0, 1'b0, "rst_mid");
        drain();
        rst = 1'b1;
        push(3, 6'b100011, 1'b0, 1'b0, "rst_mid");
        check_front();
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, 6'b100011, 1'b0, 1'b0, "rst_mid_after");
        check_front();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
